// File: rtl/sseg_signed_scan_driver_if.sv
// sseg_signed_scan_driver_if: load port and multiplexed display pins of the signed scan driver
interface sseg_signed_scan_driver_if #(
  parameter int N_DIGITS = 4,
  parameter int DATA_W   = 8
);
  logic                load;
  logic [DATA_W-1:0]   value;
  logic                is_signed;
  logic                busy;
  logic                overflow;
  logic [6:0]          SSeg;
  logic [N_DIGITS-1:0] an;
  modport master(output load, value, is_signed, input busy, overflow, SSeg, an);
  modport slave(input load, value, is_signed, output busy, overflow, SSeg, an);
endinterface

// File: rtl/sseg_signed_scan_driver.sv
// sseg_signed_scan_driver: binary-to-BCD sign/magnitude converter driving a multiplexed 7-segment display
module sseg_signed_scan_driver #(
  parameter int N_DIGITS = 4,
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 50000
) (
  input logic                    clk,
  input logic                    rst_n,
  sseg_signed_scan_driver_if.slave io
);
  localparam int ND0 = DATA_W * 30103 / 100000 + 1;
  localparam int ND  = ND0 > N_DIGITS ? ND0 : N_DIGITS;
  localparam int CW  = $clog2(DATA_W + 1);
  localparam int DW  = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int IW  = $clog2(N_DIGITS);
  localparam logic [1:0] IDLE = 2'd0, CONV = 2'd1, COMMIT = 2'd2;
  localparam logic [6:0] DASH = 7'h3F, BLANK = 7'h7F;
  logic [1:0]          state;
  logic [CW-1:0]       cnt;
  logic                neg;
  logic                ovf;
  logic                ovf_nx;
  logic                lead;
  logic [DATA_W-1:0]   bin;
  logic [4*ND-1:0]     bcd;
  logic [4*ND-1:0]     bcd_adj;
  logic [6:0]          disp [N_DIGITS];
  logic [6:0]          disp_nx [N_DIGITS];
  logic [DW-1:0]       div;
  logic [IW-1:0]       idx;
  logic [N_DIGITS-1:0] an_r;
  logic [6:0]          sseg_r;
  function automatic logic [6:0] seg(input logic [3:0] d);
    return d == 4'd0 ? 7'h40 : d == 4'd1 ? 7'h79 : d == 4'd2 ? 7'h24 : d == 4'd3 ? 7'h30 :
           d == 4'd4 ? 7'h19 : d == 4'd5 ? 7'h12 : d == 4'd6 ? 7'h02 : d == 4'd7 ? 7'h78 :
           d == 4'd8 ? 7'h00 : 7'h10;
  endfunction
  assign io.busy     = state != IDLE;
  assign io.overflow = ovf;
  assign io.an       = an_r;
  assign io.SSeg     = sseg_r;
  always_comb begin
    bcd_adj = bcd;
    for (int j = 0; j < ND; j++)
      bcd_adj[4*j +: 4] = bcd[4*j +: 4] >= 4'd5 ? bcd[4*j +: 4] + 4'd3 : bcd[4*j +: 4];
  end
  always_comb begin
    ovf_nx = |bcd[4*ND-1:4*(N_DIGITS-1)];
    lead   = 1'b1;
    for (int j = N_DIGITS - 2; j >= 0; j--) begin
      lead       = lead & (bcd[4*j +: 4] == 4'd0) & (j != 0);
      disp_nx[j] = ovf_nx ? DASH : lead ? BLANK : seg(bcd[4*j +: 4]);
    end
    disp_nx[N_DIGITS-1] = ovf_nx || neg ? DASH : BLANK;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      neg   <= 1'b0;
      bin   <= '0;
      bcd   <= '0;
      ovf   <= 1'b0;
      for (int j = 0; j < N_DIGITS; j++) disp[j] <= BLANK;
    end else if (state == IDLE && io.load) begin
      state <= CONV;
      cnt   <= '0;
      bcd   <= '0;
      neg   <= io.is_signed & io.value[DATA_W-1];
      bin   <= io.is_signed & io.value[DATA_W-1] ? -io.value : io.value;
    end else if (state == CONV) begin
      {bcd, bin} <= {bcd_adj, bin} << 1;
      cnt        <= cnt + 1'b1;
      state      <= cnt == CW'(DATA_W - 1) ? COMMIT : CONV;
    end else if (state == COMMIT) begin
      state <= IDLE;
      ovf   <= ovf_nx;
      for (int j = 0; j < N_DIGITS; j++) disp[j] <= disp_nx[j];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div    <= '0;
      idx    <= '0;
      an_r   <= ~{{(N_DIGITS-1){1'b0}}, 1'b1};
      sseg_r <= BLANK;
    end else begin
      div    <= div == DW'(CLK_DIV - 1) ? '0 : div + 1'b1;
      idx    <= div != DW'(CLK_DIV - 1) ? idx : idx == IW'(N_DIGITS - 1) ? '0 : idx + 1'b1;
      an_r   <= ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx);
      sseg_r <= disp[idx];
    end
endmodule
